// File: rtl/rasterizer_pkg.sv
// common: command encodings, FSM states and framebuffer geometry shared by the rasterizer block.
package common;
    typedef enum logic [2:0] {
        NOP   = 3'd0,
        FILL  = 3'd1,
        POINT = 3'd2,
        LINE  = 3'd3,
        RECT  = 3'd4
    } raster_command_t;

    typedef enum logic [2:0] {
        IDLE,
        DRAW_POINT,
        DRAW_LINE,
        DRAW_RECT,
        DRAW_FILL
    } raster_state_t;

    localparam logic [7:0] FB_WIDTH  = 8'd160;
    localparam logic [7:0] FB_HEIGHT = 8'd120;
    localparam int         FB_ADDR_W = 15;
endpackage

// File: rtl/rasterizer_if.sv
// rasterizer_if: CPU-to-GPU drawing command channel.
interface rasterizer_if;
    import common::*;
    raster_command_t command;
    logic [7:0]      x0, y0, x1, y1;
    logic [2:0]      colour;
    logic            execute_request;
    logic            busy;
    modport gpu (input command, x0, y0, x1, y1, colour, execute_request, output busy);
    modport cpu (output command, x0, y0, x1, y1, colour, execute_request, input busy);
endinterface

// File: rtl/rasterizer_line_stepper.sv
// rasterizer_line_stepper: Bresenham datapath; load latches endpoints, each step advances one pixel.
module rasterizer_line_stepper (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       step_i,
    input  logic [7:0] x0_i,
    input  logic [7:0] y0_i,
    input  logic [7:0] x1_i,
    input  logic [7:0] y1_i,
    output logic [7:0] x_o,
    output logic [7:0] y_o,
    output logic       done_o
);
    logic [7:0]        x_q, x_d, y_q, y_d, xe_q, ye_q, adx, ady;
    logic signed [10:0] dx_q, dy_q, err_q, err_d, e2;
    logic              sx_q, sy_q, stx, sty;

    assign adx    = x1_i >= x0_i ? x1_i - x0_i : x0_i - x1_i;
    assign ady    = y1_i >= y0_i ? y1_i - y0_i : y0_i - y1_i;
    assign e2     = err_q <<< 1;
    assign stx    = e2 >= dy_q;
    assign sty    = e2 <= dx_q;
    assign x_o    = x_q;
    assign y_o    = y_q;
    assign done_o = x_q == xe_q && y_q == ye_q;

    // Both decisions use the same e2, so a diagonal move is a single step.
    always_comb begin
        err_d = err_q + (stx ? dy_q : 11'sd0) + (sty ? dx_q : 11'sd0);
        x_d   = stx ? (sx_q ? x_q - 8'd1 : x_q + 8'd1) : x_q;
        y_d   = sty ? (sy_q ? y_q - 8'd1 : y_q + 8'd1) : y_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            xe_q  <= '0;
            ye_q  <= '0;
            dx_q  <= '0;
            dy_q  <= '0;
            err_q <= '0;
            sx_q  <= 1'b0;
            sy_q  <= 1'b0;
        end else if (load_i) begin
            x_q   <= x0_i;
            y_q   <= y0_i;
            xe_q  <= x1_i;
            ye_q  <= y1_i;
            dx_q  <= $signed({3'b0, adx});
            dy_q  <= -$signed({3'b0, ady});
            err_q <= $signed({3'b0, adx}) - $signed({3'b0, ady});
            sx_q  <= x0_i > x1_i;
            sy_q  <= y0_i > y1_i;
        end else if (step_i) begin
            x_q   <= x_d;
            y_q   <= y_d;
            err_q <= err_d;
        end
    end
endmodule

// File: rtl/rasterizer.sv
// rasterizer: executes one drawing command at a time, emitting one framebuffer write per cycle.
module rasterizer
    import common::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    rasterizer_if.gpu            gpu_if,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [2:0]           fb_colour,
    output logic                 fb_write_en
);
    raster_state_t   state_q, state_d;
    raster_command_t cmd;
    logic [7:0]      x_q, x_d, y_q, y_d, xs_q, xs_d, xe_q, xe_d, ye_q, ye_d;
    logic [7:0]      xmin, xmax, ymin, ymax, ln_x, ln_y, px, py;
    logic [2:0]      colour_q, colour_d;
    logic            ln_load, ln_step, ln_done, row_end, last;
    logic [FB_ADDR_W-1:0] xw, yw;

    assign cmd     = gpu_if.command;
    assign xmin    = gpu_if.x0 < gpu_if.x1 ? gpu_if.x0 : gpu_if.x1;
    assign xmax    = gpu_if.x0 < gpu_if.x1 ? gpu_if.x1 : gpu_if.x0;
    assign ymin    = gpu_if.y0 < gpu_if.y1 ? gpu_if.y0 : gpu_if.y1;
    assign ymax    = gpu_if.y0 < gpu_if.y1 ? gpu_if.y1 : gpu_if.y0;
    assign row_end = x_q == xe_q;
    assign last    = row_end && y_q == ye_q;

    rasterizer_line_stepper u_line (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (ln_load),
        .step_i (ln_step),
        .x0_i   (gpu_if.x0),
        .y0_i   (gpu_if.y0),
        .x1_i   (gpu_if.x1),
        .y1_i   (gpu_if.y1),
        .x_o    (ln_x),
        .y_o    (ln_y),
        .done_o (ln_done)
    );

    // FILL reuses the RECT scan over the full screen.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        xs_d     = xs_q;
        xe_d     = xe_q;
        ye_d     = ye_q;
        colour_d = colour_q;
        ln_load  = 1'b0;
        ln_step  = 1'b0;
        unique case (state_q)
            IDLE: if (gpu_if.execute_request) begin
                colour_d = gpu_if.colour;
                ln_load  = cmd == LINE;
                x_d      = cmd == FILL ? 8'd0 : cmd == POINT ? gpu_if.x0 : xmin;
                y_d      = cmd == FILL ? 8'd0 : cmd == POINT ? gpu_if.y0 : ymin;
                xs_d     = cmd == FILL ? 8'd0 : xmin;
                xe_d     = cmd == FILL ? FB_WIDTH - 8'd1 : xmax;
                ye_d     = cmd == FILL ? FB_HEIGHT - 8'd1 : ymax;
                state_d  = cmd == POINT ? DRAW_POINT : cmd == LINE ? DRAW_LINE :
                           cmd == RECT ? DRAW_RECT : cmd == FILL ? DRAW_FILL : IDLE;
            end
            DRAW_POINT: state_d = IDLE;
            DRAW_LINE: begin
                ln_step = !ln_done;
                state_d = ln_done ? IDLE : DRAW_LINE;
            end
            default: begin
                state_d = last ? IDLE : state_q;
                x_d     = row_end ? xs_q : x_q + 8'd1;
                y_d     = row_end ? y_q + 8'd1 : y_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            xs_q     <= '0;
            xe_q     <= '0;
            ye_q     <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            xs_q     <= xs_d;
            xe_q     <= xe_d;
            ye_q     <= ye_d;
            colour_q <= colour_d;
        end
    end

    assign px          = state_q == DRAW_LINE ? ln_x : x_q;
    assign py          = state_q == DRAW_LINE ? ln_y : y_q;
    assign xw          = FB_ADDR_W'(px);
    assign yw          = FB_ADDR_W'(py);
    assign fb_addr     = (yw << 7) + (yw << 5) + xw;
    assign fb_colour   = colour_q;
    assign gpu_if.busy = state_q != IDLE;
    assign fb_write_en = state_q != IDLE && px < FB_WIDTH && py < FB_HEIGHT;
endmodule

// File: tb/tb_rasterizer.sv
// tb_rasterizer: directed and random drawing commands checked against a pixel-list reference model.
module tb_rasterizer;
    import common::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] fb_addr;
    logic [2:0]  fb_colour;
    logic        fb_write_en;
    int          n_tests = 0;
    int          n_fail = 0;
    int          ex[$];
    int          ey[$];

    rasterizer_if rif ();

    rasterizer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .gpu_if      (rif),
        .fb_addr     (fb_addr),
        .fb_colour   (fb_colour),
        .fb_write_en (fb_write_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    // Ordered list of pixels a command must visit, straight from the drawing rules.
    task automatic build(input int cmd, input int x0, input int y0, input int x1, input int y1);
        int dx, dy, sx, sy, err, e2, x, y;
        ex.delete();
        ey.delete();
        case (cmd)
            2: begin ex.push_back(x0); ey.push_back(y0); end
            1: for (int j = 0; j < 120; j++) for (int i = 0; i < 160; i++) begin
                ex.push_back(i); ey.push_back(j);
            end
            4: for (int j = (y0 < y1 ? y0 : y1); j <= (y0 < y1 ? y1 : y0); j++)
                for (int i = (x0 < x1 ? x0 : x1); i <= (x0 < x1 ? x1 : x0); i++) begin
                    ex.push_back(i); ey.push_back(j);
                end
            3: begin
                dx = iabs(x1 - x0);
                dy = -iabs(y1 - y0);
                sx = x0 < x1 ? 1 : -1;
                sy = y0 < y1 ? 1 : -1;
                err = dx + dy;
                x = x0;
                y = y0;
                for (int k = 0; k < 600; k++) begin
                    ex.push_back(x); ey.push_back(y);
                    if (x == x1 && y == y1) break;
                    e2 = 2 * err;
                    if (e2 >= dy) begin err += dy; x += sx; end
                    if (e2 <= dx) begin err += dx; y += sy; end
                end
            end
            default: ;
        endcase
    endtask

    task automatic run(input int cmd, input int x0, input int y0, input int x1, input int y1,
                       input int col, input bit hold, input int abort_at);
        bit w;
        build(cmd, x0, y0, x1, y1);
        @(negedge clk);
        rif.command = raster_command_t'(cmd[2:0]);
        rif.x0 = x0[7:0];
        rif.y0 = y0[7:0];
        rif.x1 = x1[7:0];
        rif.y1 = y1[7:0];
        rif.colour = col[2:0];
        rif.execute_request = 1'b1;
        @(negedge clk);
        if (hold) begin
            rif.command = POINT;
            rif.x0 = 8'd5;
            rif.y0 = 8'd7;
            rif.colour = 3'd7;
        end else rif.execute_request = 1'b0;
        for (int i = 0; i < ex.size(); i++) begin
            if (i == abort_at) begin
                rst_n = 1'b0;
                rif.execute_request = 1'b0;
                @(negedge clk);
                check("abort_busy", rif.busy, 0);
                check("abort_we", fb_write_en, 0);
                check("abort_addr", fb_addr, 0);
                check("abort_colour", fb_colour, 0);
                rst_n = 1'b1;
                @(negedge clk);
                check("post_abort_busy", rif.busy, 0);
                check("post_abort_we", fb_write_en, 0);
                return;
            end
            w = ex[i] < 160 && ey[i] < 120;
            check("busy", rif.busy, 1);
            check("we", fb_write_en, w);
            if (w) begin
                check("addr", fb_addr, ey[i] * 160 + ex[i]);
                check("colour", fb_colour, col);
            end
            @(negedge clk);
        end
        rif.execute_request = 1'b0;
        check("done_busy", rif.busy, 0);
        check("done_we", fb_write_en, 0);
        @(negedge clk);
        check("idle_busy", rif.busy, 0);
    endtask

    initial begin
        int c, x0, y0, x1, y1;
        rif.command = NOP;
        rif.x0 = '0;
        rif.y0 = '0;
        rif.x1 = '0;
        rif.y1 = '0;
        rif.colour = '0;
        rif.execute_request = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", rif.busy, 0);
        check("rst_we", fb_write_en, 0);
        check("rst_addr", fb_addr, 0);
        check("rst_colour", fb_colour, 0);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("idle_busy", rif.busy, 0);
            check("idle_we", fb_write_en, 0);
        end
        run(2, 5, 7, 0, 0, 3, 0, -1);
        run(4, 3, 2, 1, 1, 5, 0, -1);
        run(3, 0, 0, 4, 2, 1, 0, -1);
        run(3, 4, 2, 0, 0, 1, 0, -1);
        run(3, 10, 10, 10, 10, 6, 0, -1);
        run(4, 20, 30, 20, 30, 4, 0, -1);
        run(2, 200, 50, 0, 0, 7, 0, -1);
        run(4, 158, 0, 161, 0, 2, 0, -1);
        run(3, 150, 110, 170, 125, 3, 0, -1);
        run(0, 1, 1, 2, 2, 1, 0, -1);
        run(6, 1, 1, 2, 2, 1, 0, -1);
        run(1, 0, 0, 0, 0, 2, 1, -1);
        run(1, 0, 0, 0, 0, 2, 0, 100);
        repeat (40) begin
            c = $urandom_range(0, 7);
            if (c == 1) c = 4;
            x0 = $urandom_range(0, 255);
            y0 = $urandom_range(0, 255);
            x1 = $urandom_range(0, 255);
            y1 = $urandom_range(0, 255);
            if (c == 4) begin
                x1 = $urandom_range(x0 > 8 ? x0 - 8 : 0, x0 < 247 ? x0 + 8 : 255);
                y1 = $urandom_range(y0 > 8 ? y0 - 8 : 0, y0 < 247 ? y0 + 8 : 255);
            end
            run(c, x0, y0, x1, y1, $urandom_range(0, 7), 0, -1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
